// File: rtl/id_ex_pipe_stage_if.sv
// Ready/valid bundle carrying a control word and a data word between pipeline stages.
// master drives valid/ctl/data, slave drives ready.
interface id_ex_pipe_stage_if #(
    parameter int CTL_W  = 9,
    parameter int DATA_W = 144
);
    logic              valid;
    logic              ready;
    logic [CTL_W-1:0]  ctl;
    logic [DATA_W-1:0] data;

    modport master (output valid, output ctl, output data, input ready);
    modport slave  (input valid, input ctl, input data, output ready);
endinterface

// File: rtl/id_ex_pipe_stage.sv
// Ready/valid pipeline register (ID/EX and later boundaries) with optional skid entry,
// flush/bubble insertion and a saturating stall counter.
//   state | meaning
//   EMPTY | nothing held, out_valid=0
//   ONE   | main entry M valid, skid entry S empty
//   FULL  | M and S valid, in_ready=0 (only reachable with SKID=1)
module id_ex_pipe_stage #(
    parameter int CTL_W  = 9,
    parameter int DATA_W = 144,
    parameter int SKID   = 1,
    parameter int CNT_W  = 16
) (
    input  logic               clk,
    input  logic               rst,
    id_ex_pipe_stage_if.slave  up,
    id_ex_pipe_stage_if.master dn,
    input  logic               flush,
    input  logic               clr_cnt,
    output logic [CNT_W-1:0]   stall_cnt
);
    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;

    state_t            state;
    state_t            state_nx;
    logic [CTL_W-1:0]  m_ctl;
    logic [CTL_W-1:0]  s_ctl;
    logic [DATA_W-1:0] m_data;
    logic [DATA_W-1:0] s_data;
    logic              m_valid;
    logic              xfer_in;
    logic              load_m_in;
    logic              load_m_s;
    logic              load_s_in;

    assign m_valid = (state != EMPTY);

    // With a skid entry, ready comes straight from a flop; without it, ready looks at downstream.
    assign up.ready = (SKID != 0) ? (state != FULL) : (!m_valid || dn.ready);
    assign xfer_in  = up.valid && up.ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= EMPTY;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (flush) begin
            state_nx = EMPTY;
        end else begin
            case (state)
                EMPTY: if (xfer_in) state_nx = ONE;
                ONE: begin
                    if (xfer_in && !dn.ready)      state_nx = FULL;
                    else if (!xfer_in && dn.ready) state_nx = EMPTY;
                end
                FULL:    if (dn.ready) state_nx = ONE;
                default: state_nx = EMPTY;
            endcase
        end
    end

    always_comb begin
        load_m_in = 1'b0;
        load_m_s  = 1'b0;
        load_s_in = 1'b0;
        dn.valid  = m_valid;
        dn.ctl    = m_valid ? m_ctl : '0;
        dn.data   = m_data;
        if (!flush) begin
            case (state)
                EMPTY: load_m_in = xfer_in;
                ONE: begin
                    load_m_in = xfer_in && dn.ready;
                    load_s_in = xfer_in && !dn.ready;
                end
                FULL:    load_m_s = dn.ready;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_ctl  <= '0;
            m_data <= '0;
            s_ctl  <= '0;
            s_data <= '0;
        end else begin
            if (load_m_in) begin
                m_ctl  <= up.ctl;
                m_data <= up.data;
            end else if (load_m_s) begin
                m_ctl  <= s_ctl;
                m_data <= s_data;
            end
            if (load_s_in) begin
                s_ctl  <= up.ctl;
                s_data <= up.data;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            stall_cnt <= '0;
        else if (clr_cnt)
            stall_cnt <= '0;
        else if (m_valid && !dn.ready && (stall_cnt != {CNT_W{1'b1}}))
            stall_cnt <= stall_cnt + 1'b1;
    end
endmodule

// File: tb/tb_id_ex_pipe_stage.sv
// Drives a SKID=1/CNT_W=4 and a SKID=0/CNT_W=16 instance with the same stimulus and
// compares both against queue-based reference models every cycle.
module tb_id_ex_pipe_stage;
    localparam int CTL_W  = 9;
    localparam int DATA_W = 144;
    localparam int CNT_A  = 4;
    localparam int CNT_B  = 16;
    localparam int MAX_A  = (1 << CNT_A) - 1;
    localparam int MAX_B  = (1 << CNT_B) - 1;

    typedef struct packed {
        logic [CTL_W-1:0]  ctl;
        logic [DATA_W-1:0] data;
    } ent_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_valid = 1'b0;
    logic              out_ready = 1'b0;
    logic              flush = 1'b0;
    logic              clr_cnt = 1'b0;
    logic [CTL_W-1:0]  in_ctl = '0;
    logic [DATA_W-1:0] in_data = '0;
    logic [CNT_A-1:0]  stall_a;
    logic [CNT_B-1:0]  stall_b;

    int   vectors = 0;
    int   miscompares = 0;
    ent_t qa[$];
    ent_t qb[$];
    int   cnta = 0;
    int   cntb = 0;

    always #5 clk = ~clk;

    id_ex_pipe_stage_if #(.CTL_W(CTL_W), .DATA_W(DATA_W)) ua ();
    id_ex_pipe_stage_if #(.CTL_W(CTL_W), .DATA_W(DATA_W)) da ();
    id_ex_pipe_stage_if #(.CTL_W(CTL_W), .DATA_W(DATA_W)) ub ();
    id_ex_pipe_stage_if #(.CTL_W(CTL_W), .DATA_W(DATA_W)) db ();

    assign ua.valid = in_valid;
    assign ua.ctl   = in_ctl;
    assign ua.data  = in_data;
    assign da.ready = out_ready;
    assign ub.valid = in_valid;
    assign ub.ctl   = in_ctl;
    assign ub.data  = in_data;
    assign db.ready = out_ready;

    id_ex_pipe_stage #(.CTL_W(CTL_W), .DATA_W(DATA_W), .SKID(1), .CNT_W(CNT_A)) dut_a (
        .clk(clk), .rst(rst), .up(ua), .dn(da),
        .flush(flush), .clr_cnt(clr_cnt), .stall_cnt(stall_a)
    );

    id_ex_pipe_stage #(.CTL_W(CTL_W), .DATA_W(DATA_W), .SKID(0), .CNT_W(CNT_B)) dut_b (
        .clk(clk), .rst(rst), .up(ub), .dn(db),
        .flush(flush), .clr_cnt(clr_cnt), .stall_cnt(stall_b)
    );

    task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        logic [CTL_W-1:0] ea;
        logic [CTL_W-1:0] eb;
        ea = (qa.size() > 0) ? qa[0].ctl : '0;
        eb = (qb.size() > 0) ? qb[0].ctl : '0;
        chk("a_valid", 160'(da.valid), 160'(qa.size() > 0));
        chk("a_ctl",   160'(da.ctl),   160'(ea));
        if (qa.size() > 0) chk("a_data", 160'(da.data), 160'(qa[0].data));
        chk("a_ready", 160'(ua.ready), 160'(qa.size() < 2));
        chk("a_cnt",   160'(stall_a),  160'(cnta));
        chk("b_valid", 160'(db.valid), 160'(qb.size() > 0));
        chk("b_ctl",   160'(db.ctl),   160'(eb));
        if (qb.size() > 0) chk("b_data", 160'(db.data), 160'(qb[0].data));
        chk("b_ready", 160'(ub.ready), 160'(qb.size() == 0 || out_ready));
        chk("b_cnt",   160'(stall_b),  160'(cntb));
    endtask

    // Called at a negedge: apply inputs, check, advance one clock, update models.
    task automatic step(input logic iv, input logic [CTL_W-1:0] c, input logic [DATA_W-1:0] d,
                        input logic ordy, input logic fl, input logic cl);
        bit   xin_a, xout_a, xin_b, xout_b;
        ent_t e;
        in_valid  = iv;
        in_ctl    = c;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
        clr_cnt   = cl;
        #1;
        check_all();
        @(posedge clk);
        e.ctl  = c;
        e.data = d;
        xin_a  = iv && (qa.size() < 2);
        xout_a = (qa.size() > 0) && ordy;
        xin_b  = iv && (qb.size() == 0 || ordy);
        xout_b = (qb.size() > 0) && ordy;
        if (cl) cnta = 0;
        else if (qa.size() > 0 && !ordy && cnta < MAX_A) cnta++;
        if (cl) cntb = 0;
        else if (qb.size() > 0 && !ordy && cntb < MAX_B) cntb++;
        if (fl) begin
            qa.delete();
            qb.delete();
        end else begin
            if (xout_a) void'(qa.pop_front());
            if (xin_a)  qa.push_back(e);
            if (xout_b) void'(qb.pop_front());
            if (xin_b)  qb.push_back(e);
        end
        @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_a_valid"}, 160'(da.valid), 160'(0));
        chk({tag, "_a_ctl"},   160'(da.ctl),   160'(0));
        chk({tag, "_a_data"},  160'(da.data),  160'(0));
        chk({tag, "_a_ready"}, 160'(ua.ready), 160'(1));
        chk({tag, "_a_cnt"},   160'(stall_a),  160'(0));
        chk({tag, "_b_valid"}, 160'(db.valid), 160'(0));
        chk({tag, "_b_data"},  160'(db.data),  160'(0));
        chk({tag, "_b_cnt"},   160'(stall_b),  160'(0));
    endtask

    initial begin
        logic [DATA_W-1:0] rd;
        logic [CTL_W-1:0]  rc;
        logic [31:0]       r0, r1, r2, r3;

        @(negedge clk);
        @(negedge clk);
        check_reset_outputs("por");
        rst = 1'b0;

        // streaming at full throughput
        for (int i = 1; i <= 8; i++) step(1'b1, 9'h1FF, DATA_W'(i), 1'b1, 1'b0, 1'b0);
        step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
        step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);

        // backpressure: A then B captured, 3 stalled cycles, then drain in order
        step(1'b0, '0, '0, 1'b1, 1'b0, 1'b1);
        step(1'b1, 9'h0A5, DATA_W'(16'h11), 1'b0, 1'b0, 1'b0);
        step(1'b1, 9'h05A, DATA_W'(16'h22), 1'b0, 1'b0, 1'b0);
        step(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        step(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);

        // flush while full with C offered; D afterwards must flow normally
        step(1'b1, 9'h011, DATA_W'(16'h11), 1'b0, 1'b0, 1'b0);
        step(1'b1, 9'h022, DATA_W'(16'h22), 1'b0, 1'b0, 1'b0);
        step(1'b1, 9'h033, DATA_W'(16'h33), 1'b0, 1'b1, 1'b0);
        step(1'b1, 9'h044, DATA_W'(16'h44), 1'b1, 1'b0, 1'b0);
        step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
        step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);

        // toggling downstream ready with continuous upstream valid
        for (int i = 0; i < 10; i++)
            step(1'b1, 9'(i + 1), DATA_W'(32'h100 + i), (i % 2) == 0, 1'b0, 1'b0);
        step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
        step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);

        // long stall saturates the 4-bit counter; clear wins over a concurrent stall
        step(1'b0, '0, '0, 1'b1, 1'b0, 1'b1);
        step(1'b1, 9'h155, DATA_W'(16'h55), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) step(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
        step(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);

        // async reset mid-cycle while full
        step(1'b1, 9'h066, DATA_W'(16'h66), 1'b0, 1'b0, 1'b0);
        step(1'b1, 9'h077, DATA_W'(16'h77), 1'b0, 1'b0, 1'b0);
        #2 rst = 1'b1;
        #1;
        check_reset_outputs("arst");
        qa.delete();
        qb.delete();
        cnta = 0;
        cntb = 0;
        @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        step(1'b1, 9'h188, DATA_W'(16'h88), 1'b1, 1'b0, 1'b0);
        step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
        step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            r0 = $urandom();
            r1 = $urandom();
            r2 = $urandom();
            r3 = $urandom();
            rd = {r0, r1, r2, r3, 16'(i)};
            rc = 9'($urandom());
            step($urandom_range(0, 3) != 0, rc, rd, $urandom_range(0, 2) != 0,
                 $urandom_range(0, 31) == 0, $urandom_range(0, 63) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/id_ex_pipe_stage.md
Name: id_ex_pipe_stage

Overview:
- Parametrised successor to the fixed ID/EX latch. It is a ready/valid pipeline register that carries a control bundle and a data bundle.
- Adds stall (backpressure), flush/bubble insertion, an optional skid buffer for full throughput under registered ready, and a saturating stall counter.
- Sits between decode and execute. It is also reusable for the EX/MEM and MEM/WB boundaries by changing the widths.

Parameters:
- CTL_W, 9, control bundle width (default: wb 2 + mem 3 + ex 4).
- DATA_W, 144, data bundle width (default: npc, rd1, rd2, sext at 32 each, plus rt 5, rd 5, funct 6).
- SKID, 1, 1 = two-entry skid buffer with registered in_ready; 0 = single entry with combinational in_ready.
- CNT_W, 16, stall counter width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  upstream has an instruction.
- in_ready  out  1  stage can accept; transfer occurs when in_valid & in_ready.
- in_ctl  in  CTL_W  control bundle from decode.
- in_data  in  DATA_W  data bundle from decode.
- out_valid  out  1  stage holds a valid instruction.
- out_ready  in  1  execute can consume; transfer occurs when out_valid & out_ready.
- out_ctl  out  CTL_W  latched control; forced to 0 whenever out_valid=0.
- out_data  out  DATA_W  latched data.
- flush  in  1  synchronous kill of all held and incoming instructions.
- clr_cnt  in  1  synchronous clear of stall_cnt.
- stall_cnt  out  CNT_W  cycles with out_valid & !out_ready.

Behaviour:
- Reset (async, immediate):
  - out_valid=0, out_ctl=0, out_data=0, stall_cnt=0, skid entry invalid and zeroed.
  - in_ready=1 in both modes.
- Latency: one cycle. Data accepted at edge N appears on out_* after edge N.
- No combinational path from in_* to out_*.
- Bubble rule: when out_valid=0, out_ctl reads as 0, i.e. a NOP with no write-back and no memory access. out_data keeps its last value; its content is don't-care when invalid.
- SKID=1 state machine (main entry M drives out_*, skid entry S; in_ready = !S.valid, registered):
  - EMPTY: in xfer -> ONE, M<=in. Otherwise stay.
  - ONE:
    - in xfer & out_ready -> ONE, M<=in.
    - in xfer & !out_ready -> FULL, S<=in, M held.
    - no in xfer & out_ready -> EMPTY.
    - otherwise hold.
  - FULL (in_ready=0): out_ready -> ONE, M<=S, S invalid. Otherwise hold.
  - Ordering is always preserved: S never bypasses M.
- SKID=0:
  - in_ready = !out_valid | out_ready, combinational.
  - M<=in on in xfer; out_valid<=0 on out xfer without in xfer.
  - Backpressure propagates in the same cycle.
- flush (highest priority, synchronous):
  - At the edge: M and S are invalidated, state goes to EMPTY, out_ctl=0.
  - Any in xfer in the same cycle is dropped.
  - An out xfer in the same cycle still counts as consumed by downstream.
- Simultaneous flush & rst: rst wins.
- Stall while holding: M and S contents are bit-stable across any number of cycles with out_ready=0.
- stall_cnt:
  - +1 on each edge where out_valid & !out_ready.
  - Saturates at 2^CNT_W-1 with no wrap.
  - clr_cnt sets it to 0 and has priority over increment.
  - flush does not affect it.
- Reset mid-operation: all held instructions are lost; no partial state survives.

Test Plan:
- Streaming, SKID=1, out_ready=1, in_valid=1, in_data=1..8, in_ctl=9'h1FF -> out_data 1..8 on consecutive cycles one cycle later; in_ready stays 1; stall_cnt=0.
- Backpressure, SKID=1: send A=0x11, B=0x22, then out_ready=0 for 3 cycles -> in_ready=0 after B is captured; out_data holds 0x11; stall_cnt=3. On release, 0x11 then 0x22 emerge in order with no loss or duplicate.
- Flush while FULL with in_valid=1 (C=0x33) -> next cycle out_valid=0, out_ctl=0, in_ready=1. C never appears; a subsequent D=0x44 emerges normally.
- SKID=0, out_ready toggling 1,0,1,0 with continuous in_valid -> in_ready mirrors out_ready combinationally whenever out_valid=1; every accepted value emerges exactly once.
- Counter: CNT_W=4, hold out_ready=0 with out_valid=1 for 20 cycles -> stall_cnt=15 (saturated). clr_cnt together with a stall -> 0.
- Async rst asserted mid-cycle while FULL -> outputs go to 0 immediately without a clock; in_ready=1; after release, first accepted value is output correctly.
